// File: rtl/draw_pkg.sv
// Shared definitions for the draw arbiter: FSM encoding, parameter defaults,
// the background colour and an index-width helper.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } draw_state_e;

    localparam int          N_REQ_DEF    = 4;
    localparam logic [19:0] HOLD_MAX_DEF = 20'd4096;
    localparam logic [2:0]  BLACK        = 3'b000;

    // Width of a requester index; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_arb_pick.sv
// Combinational winner selection for the draw arbiter.
// Build option: DRAW_RR_EN selects round-robin (search starts after the
// last winner); without it the lowest requesting index wins.
module draw_arb_pick
    import draw_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifdef DRAW_RR_EN
    input  logic [IDX_W-1:0] last_win,
`endif
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    // Scan the requesters in priority order and take the first one asserting req.
    always_comb begin
        int cand;
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef DRAW_RR_EN
            cand = (int'(last_win) + 1 + k) % N_REQ;
`else
            cand = k;
`endif
            if (!win_valid && req[cand]) begin
                win_idx   = IDX_W'(cand);
                win_valid = 1'b1;
            end else begin
                win_idx   = win_idx;
                win_valid = win_valid;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates VGA pixel-write access among N_REQ drawing engines.
// A requester is granted for a burst that ends on its done pulse or after
// HOLD_MAX cycles (forced release, latched in timeout_err). The winner's
// pixel stream is registered onto x/y/colour/writeEn with one cycle latency.
// Build option: DRAW_RR_EN enables round-robin arbitration; the default
// build uses fixed priority (lowest index wins).
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int          N_REQ    = N_REQ_DEF,
    parameter logic [19:0] HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      done,
    input  logic [10*N_REQ-1:0]   x_in,
    input  logic [10*N_REQ-1:0]   y_in,
    input  logic [3*N_REQ-1:0]    colour_in,
    input  logic [N_REQ-1:0]      plot_in,
    output logic [N_REQ-1:0]      grant,
    output logic [9:0]            x,
    output logic [9:0]            y,
    output logic [2:0]            colour,
    output logic                  writeEn,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IDX_W = idx_width(N_REQ);

    draw_state_e        state_r, state_nxt_s;
    logic [IDX_W-1:0]   win_idx_r, win_idx_nxt_s;
    logic [19:0]        hold_cnt_r, hold_cnt_nxt_s;
    logic [N_REQ-1:0]   grant_r, grant_nxt_s;
    logic [9:0]         x_r, x_nxt_s, y_r, y_nxt_s;
    logic [2:0]         colour_r, colour_nxt_s;
    logic               we_r, we_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               tmo_r, tmo_nxt_s;

    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic               done_win_s;
    logic               hold_hit_s;
    logic               release_s;

`ifdef DRAW_RR_EN
    logic [IDX_W-1:0]   last_win_r, last_win_nxt_s;
`endif

    draw_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req),
`ifdef DRAW_RR_EN
        .last_win  (last_win_r),
`endif
        .win_idx   (pick_idx_s),
        .win_valid (pick_valid_s)
    );

    // Only the granted requester's done counts; the hold limit is hit on the
    // BUSY cycle whose increment brings the counter to HOLD_MAX.
    assign done_win_s = done[win_idx_r];
    assign hold_hit_s = ({1'b0, hold_cnt_r} + 21'd1) >= {1'b0, HOLD_MAX};
    assign release_s  = (state_r == BUSY) && (done_win_s || hold_hit_s);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) state_nxt_s = ARB;
                else      state_nxt_s = IDLE;
            end
            ARB: begin
                if (pick_valid_s) state_nxt_s = BUSY;
                else              state_nxt_s = IDLE;
            end
            BUSY: begin
                if (release_s) state_nxt_s = GAP;
                else           state_nxt_s = BUSY;
            end
            GAP:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of all registered outputs and datapath state.
    always_comb begin
        win_idx_nxt_s  = win_idx_r;
        hold_cnt_nxt_s = hold_cnt_r;
        grant_nxt_s    = '0;
        x_nxt_s        = x_r;
        y_nxt_s        = y_r;
        colour_nxt_s   = colour_r;
        we_nxt_s       = 1'b0;
        tmo_nxt_s      = tmo_r;
        busy_nxt_s     = (state_nxt_s != IDLE);
`ifdef DRAW_RR_EN
        last_win_nxt_s = last_win_r;
`endif
        case (state_r)
            ARB: begin
                hold_cnt_nxt_s = 20'd0;
                if (pick_valid_s) begin
                    win_idx_nxt_s = pick_idx_s;
`ifdef DRAW_RR_EN
                    last_win_nxt_s = pick_idx_s;
`endif
                    for (int i = 0; i < N_REQ; i++) begin
                        grant_nxt_s[i] = (pick_idx_s == IDX_W'(i));
                    end
                end else begin
                    grant_nxt_s = '0;
                end
            end
            BUSY: begin
                x_nxt_s      = x_in[10*int'(win_idx_r) +: 10];
                y_nxt_s      = y_in[10*int'(win_idx_r) +: 10];
                colour_nxt_s = colour_in[3*int'(win_idx_r) +: 3];
                we_nxt_s     = plot_in[win_idx_r];
                if (hold_cnt_r != HOLD_MAX) hold_cnt_nxt_s = hold_cnt_r + 20'd1;
                else                        hold_cnt_nxt_s = hold_cnt_r;
                if (release_s) grant_nxt_s = '0;
                else           grant_nxt_s = grant_r;
                if (hold_hit_s && !done_win_s) tmo_nxt_s = 1'b1;
                else                           tmo_nxt_s = tmo_r;
            end
            default: begin
                grant_nxt_s = '0;
                we_nxt_s    = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_idx_r  <= '0;
            hold_cnt_r <= 20'd0;
            grant_r    <= '0;
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            colour_r   <= BLACK;
            we_r       <= 1'b0;
            busy_r     <= 1'b0;
            tmo_r      <= 1'b0;
`ifdef DRAW_RR_EN
            last_win_r <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            win_idx_r  <= win_idx_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            grant_r    <= grant_nxt_s;
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            colour_r   <= colour_nxt_s;
            we_r       <= we_nxt_s;
            busy_r     <= busy_nxt_s;
            tmo_r      <= tmo_nxt_s;
`ifdef DRAW_RR_EN
            last_win_r <= last_win_nxt_s;
`endif
        end
    end

    assign grant       = grant_r;
    assign x           = x_r;
    assign y           = y_r;
    assign colour      = colour_r;
    assign writeEn     = we_r;
    assign busy        = busy_r;
    assign timeout_err = tmo_r;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed self-checking bench for draw_arbiter (N_REQ=4, HOLD_MAX=16).
module tb_draw_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, done, plot_in, grant;
    logic [39:0] x_in, y_in;
    logic [11:0] colour_in;
    logic [9:0]  x, y;
    logic [2:0]  colour;
    logic        writeEn, busy, timeout_err;

    int checks   = 0;
    int failures = 0;

    draw_arbiter #(.N_REQ(4), .HOLD_MAX(20'd16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .plot_in     (plot_in),
        .grant       (grant),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .writeEn     (writeEn),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [9:0] xv, input logic [9:0] yv, input logic [2:0] cv);
        x_in[10*i +: 10]     = xv;
        y_in[10*i +: 10]     = yv;
        colour_in[3*i +: 3]  = cv;
    endtask

    // Advance until any grant appears (bounded), then compare it.
    task automatic wait_grant(input string tag, input logic [3:0] exp);
        for (int n = 0; n < 10; n++) begin
            if (grant != 4'b0000) break;
            tick();
        end
        check_eq(tag, {28'd0, grant}, {28'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] exp_g;
    int         hold_cycles;

    initial begin
        reset = 1'b1; req = 4'b0; done = 4'b0; plot_in = 4'b0;
        x_in = 40'd0; y_in = 40'd0; colour_in = 12'd0;
        tick();
        tick();
        check_eq("rst_grant", {28'd0, grant}, 32'd0);
        check_eq("rst_we",    {31'd0, writeEn}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_tmo",   {31'd0, timeout_err}, 32'd0);
        check_eq("rst_xyc",   {2'd0, x, y, colour}, 32'd0);
        reset = 1'b0;
        tick();

        // Single burst from requester 2.
        req = 4'b0100;
        tick();
        check_eq("arb_busy",  {31'd0, busy}, 32'd1);
        check_eq("arb_grant", {28'd0, grant}, 32'd0);
        tick();
        check_eq("b2_grant",  {28'd0, grant}, 32'h4);
        set_pix(2, 10'd5, 10'd7, 3'b101);
        plot_in = 4'b0100;
        tick();
        plot_in = 4'b0000;
        check_eq("b2_we",     {31'd0, writeEn}, 32'd1);
        check_eq("b2_xyc",    {2'd0, x, y, colour}, {2'd0, 10'd5, 10'd7, 3'b101});
        tick();
        check_eq("b2_we_off", {31'd0, writeEn}, 32'd0);
        check_eq("b2_x_hold", {22'd0, x}, 32'd5);
        req = 4'b0000;
        done = 4'b0100;
        tick();
        done = 4'b0000;
        check_eq("gap_grant", {28'd0, grant}, 32'd0);
        check_eq("gap_busy",  {31'd0, busy}, 32'd1);
        check_eq("gap_we",    {31'd0, writeEn}, 32'd0);
        tick();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Four back-to-back bursts with every requester asking.
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 4; b++) begin
`ifdef DRAW_RR_EN
            exp_g = 4'b0001 << b;
`else
            exp_g = 4'b0001;
`endif
            wait_grant($sformatf("burst%0d_grant", b), exp_g);
            done = grant;
            tick();
            done = 4'b0000;
        end
        req = 4'b0000;
        tick();
        tick();

        // Forced release: requester 1 never signals done; it also drops req.
        do_reset();
        req = 4'b0010;
        wait_grant("tmo_grant", 4'b0010);
        req = 4'b0000;
        hold_cycles = 1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (grant == 4'b0000) break;
            hold_cycles++;
        end
        check_eq("tmo_cycles", hold_cycles, 32'd16);
        check_eq("tmo_flag",   {31'd0, timeout_err}, 32'd1);
        tick();
        tick();
        req = 4'b0001;
        wait_grant("after_tmo_grant", 4'b0001);
        req = 4'b0000;
        done = 4'b0001;
        tick();
        done = 4'b0000;
        tick();
        check_eq("tmo_sticky", {31'd0, timeout_err}, 32'd1);

        // Non-granted strobes and done ignored; final pixel with done.
        req = 4'b0010;
        wait_grant("mux_grant", 4'b0010);
        req = 4'b0000;
        set_pix(1, 10'd100, 10'd11, 3'd3);
        set_pix(3, 10'd300, 10'd33, 3'd6);
        plot_in = 4'b1010;
        tick();
        check_eq("mux_we",  {31'd0, writeEn}, 32'd1);
        check_eq("mux_xyc", {2'd0, x, y, colour}, {2'd0, 10'd100, 10'd11, 3'd3});
        plot_in = 4'b1000;
        done = 4'b1000;
        tick();
        check_eq("ign_done_grant", {28'd0, grant}, 32'h2);
        check_eq("ign_plot_we",    {31'd0, writeEn}, 32'd0);
        set_pix(1, 10'd200, 10'd22, 3'd1);
        plot_in = 4'b0010;
        done = 4'b0010;
        tick();
        plot_in = 4'b0000;
        done = 4'b0000;
        check_eq("last_we",    {31'd0, writeEn}, 32'd1);
        check_eq("last_xyc",   {2'd0, x, y, colour}, {2'd0, 10'd200, 10'd22, 3'd1});
        check_eq("last_grant", {28'd0, grant}, 32'd0);
        tick();
        check_eq("last_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("last_we_off",    {31'd0, writeEn}, 32'd0);

        // Asynchronous reset in the middle of a burst.
        req = 4'b0100;
        wait_grant("ar_grant", 4'b0100);
        set_pix(2, 10'd9, 10'd9, 3'd7);
        plot_in = 4'b0100;
        tick();
        check_eq("ar_we_pre", {31'd0, writeEn}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_grant0", {28'd0, grant}, 32'd0);
        check_eq("ar_we0",    {31'd0, writeEn}, 32'd0);
        check_eq("ar_busy0",  {31'd0, busy}, 32'd0);
        check_eq("ar_tmo0",   {31'd0, timeout_err}, 32'd0);
        check_eq("ar_xyc0",   {2'd0, x, y, colour}, 32'd0);
        plot_in = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        check_eq("ar_restart_busy", {31'd0, busy}, 32'd1);
        wait_grant("ar_restart_grant", 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of drawing requesters (ball, bricks, platform, loader).
REQ-002 Parameter HOLD_MAX, default 20'd4096: maximum cycles one grant may last before forced release.
REQ-003 clk  input  1  single system clock, CLOCK_50 domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester draw request, level, held until granted.
REQ-006 done  input  N_REQ  per-requester end-of-burst pulse, sampled only from the granted requester.
REQ-007 x_in, y_in  input  10*N_REQ each  packed pixel coordinates, requester i at bits [10i+9:10i].
REQ-008 colour_in  input  3*N_REQ  packed pixel colour.
REQ-009 plot_in  input  N_REQ  per-requester pixel write strobe.
REQ-010 grant  output  N_REQ  one-hot grant, all-zero when idle.
REQ-011 x, y  output  10 each  registered pixel coordinates to the VGA adapter.
REQ-012 colour  output  3  registered pixel colour.
REQ-013 writeEn  output  1  registered plot strobe to the VGA adapter.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout_err  output  1  sticky flag, set on forced release.

Function
REQ-016 FSM states: IDLE, ARB, BUSY, GAP.
REQ-017 IDLE -> ARB when any req bit is high, otherwise stay in IDLE.
REQ-018 ARB lasts one cycle, latches the winner index, and drives grant one-hot from the next cycle.
REQ-019 BUSY -> GAP on done[winner], or when the hold counter reaches HOLD_MAX.
REQ-020 GAP lasts one cycle with grant zero and writeEn zero, then goes to IDLE.
REQ-021 Pixel path: in BUSY, x/y/colour/writeEn register the winner's x_in/y_in/colour_in/plot_in.
REQ-022 Pixel path latency is 1 cycle.
REQ-023 Outside BUSY, writeEn is 0 and x/y/colour hold their last values.
REQ-024 Strobes from non-granted requesters are ignored, with no buffering.
REQ-025 A done pulse from a non-granted requester is ignored.
REQ-026 If plot_in and done of the winner coincide, that pixel is still written and the state moves to GAP.
REQ-027 Hold counter is 20 bits, cleared in ARB, increments each BUSY cycle, saturates at HOLD_MAX.
REQ-028 A forced release sets timeout_err, which stays set until reset.
REQ-029 A requester dropping req while granted does not release the grant; only done or timeout does.
REQ-030 If no req bit is high in ARB (a glitch case), the FSM returns to IDLE with grant zero.

Reset
REQ-031 On reset assertion, asynchronously: state=IDLE, grant=0, writeEn=0, x=0, y=0, colour=0, busy=0, timeout_err=0, hold counter=0, last-winner=N_REQ-1.
REQ-032 Reset mid-BUSY abandons the burst with no further writeEn.
REQ-033 After reset deasserts, arbitration restarts in IDLE on the next edge.

Configuration
REQ-034 Macro DRAW_RR_EN defined: round-robin; search starts at last-winner+1 modulo N_REQ; last-winner updates in ARB.
REQ-035 Macro DRAW_RR_EN undefined: fixed priority; the lowest index wins; last-winner register is absent.

Structure
REQ-036 Shared package draw_pkg holds the state encoding (IDLE=0, ARB=1, BUSY=2, GAP=3), N_REQ default, HOLD_MAX default, and the colour BLACK=3'b000.
REQ-037 One sub-module, draw_arb_pick, is combinational: from req and last-winner it produces the winner index and a valid flag, and contains the DRAW_RR_EN selection.

Verification
REQ-038 req=4'b0100, plot_in[2] pulses with x=10'd5, y=10'd7, colour=3'b101, then done[2] -> grant=4'b0100 two cycles after req; writeEn with (5,7,101) one cycle after each strobe; grant=0 in GAP.
REQ-039 req=4'b1111 held across four bursts, each ended by done -> fixed priority: grant 0001 every burst; DRAW_RR_EN: grants 0001, 0010, 0100, 1000 in order.
REQ-040 Winner 1 never pulses done, HOLD_MAX=20'd16 -> grant drops after 16 BUSY cycles; timeout_err=1, still 1 after later normal bursts.
REQ-041 plot_in=4'b1010 while grant=4'b0010 -> only requester 1's pixel reaches x/y/colour; exactly one writeEn per cycle.
REQ-042 reset asserted mid-BUSY with plot_in high -> writeEn=0 and grant=0 immediately, without a clock edge; all outputs at reset values.
REQ-043 plot_in and done of the winner in the same cycle -> that final pixel is written, then GAP, then IDLE.
